// File: rtl/adc_uart_framer.sv
// ADC sample framer: periodic 12-bit capture into a FWFT FIFO, then a
// 3-byte frame (sync, seq/MSBs, LSBs) handed to uart_tx byte by byte.
module adc_uart_framer #(
  parameter int unsigned SAMPLE_DIV = 2500,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enb,
  input  logic [11:0]                   i_adc_data,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      seq_q, seq_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     frame_q, frame_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            overflow_q, overflow_d;

  logic            tick;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic [AW:0]     level;

  assign level = wr_ptr_q - rd_ptr_q;

  always_comb begin
    tick  = i_enb && (cnt_q == CNT_MAX);
    empty = (level == '0);
    full  = (level == DEPTH_L);
    pop   = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a tick on a full FIFO still lands.
    push  = tick && (!full || pop);

    cnt_d      = (!i_enb || tick) ? '0 : cnt_q + 1'b1;
    seq_d      = tick ? seq_q + 4'd1 : seq_q;
    overflow_d = overflow_q | (tick & full & ~pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          frame_d    = mem_q[rd_ptr_q[AW-1:0]];
          state_d    = B0;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      B0, B1, B2: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_BUSY;
          idx_d      = (state_q == B0) ? 2'd1 : (state_q == B1) ? 2'd2 : 2'd3;
        end
      end
      // Ready must drop before we trust it again, else the same byte goes twice.
      WAIT_BUSY: begin
        if (!i_tx_ready) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (i_tx_ready) begin
          case (idx_q)
            2'd1: begin
              state_d    = B1;
              tx_data_d  = frame_q[15:8];
              tx_valid_d = 1'b1;
            end
            2'd2: begin
              state_d    = B2;
              tx_data_d  = frame_q[7:0];
              tx_valid_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: pointers define which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {seq_q, i_adc_data};
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_overflow   = overflow_q;
  assign o_fifo_level = level;
  assign o_busy       = (state_q != IDLE) || (level != '0);

endmodule

// File: doc/adc_uart_framer.md
Name: adc_uart_framer

Overview:
- Periodically samples the 12-bit ADC channel value and buffers samples in a small FIFO.
- Serialises each sample into a 3-byte frame (sync byte, sequence/MSBs, LSBs) and feeds the frame to uart_tx through a valid/ready handshake.
- Sits between the ADC controller CH output and uart_tx in top, replacing the direct ch0-to-i_data_tx register.

Parameters:
- SAMPLE_DIV, 2500, clock cycles between sample ticks; legal range ≥ 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- FIFO_DEPTH, 4, sample entries buffered; power of two, ≥ 2.

Ports:
- i_clk  input  1  system clock (PLL c0).
- i_rst_n  input  1  asynchronous active-low reset.
- i_enb  input  1  sampling enable.
- i_adc_data  input  12  current ADC channel reading (CH0).
- o_tx_data  output  8  byte to uart_tx.
- o_tx_valid  output  1  o_tx_data holds a byte to send.
- i_tx_ready  input  1  uart_tx idle / ready (ready_tx).
- o_overflow  output  1  sticky: a sample was dropped on a full FIFO.
- o_busy  output  1  frame in progress or FIFO non-empty.
- o_fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently stored.

Behaviour:
- Reset (async assert, sync release): all outputs 0; tick counter, sequence counter, FIFO pointers cleared; FSM in IDLE.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while i_enb=1, then wraps to 0.
  - Tick pulses for one cycle when the count equals SAMPLE_DIV-1.
  - When i_enb=0, the counter holds at 0 and no ticks occur.
- Sample capture on tick:
  - Entry = {seq[3:0], i_adc_data[11:0]}, using the i_adc_data value on the tick cycle.
  - seq increments (mod 16, 15→0) on every tick, including dropped ones, so drops show as sequence gaps.
  - FIFO full on tick: entry discarded, o_overflow set to 1 and held until reset.
  - Push and pop in the same cycle on a full FIFO: the pop happens first, so the push is accepted and no overflow is flagged.
- FIFO: synchronous, first-word-fall-through; o_fifo_level updates the cycle after the push/pop edge.
- FSM states: IDLE, B0, B1, B2, WAIT_BUSY, WAIT_READY.
  - IDLE: if FIFO non-empty, pop the head into a frame register in the same cycle; go to B0.
  - B0/B1/B2: o_tx_valid=1.
    - B0: o_tx_data=SYNC_BYTE.
    - B1: o_tx_data={seq, sample[11:8]}.
    - B2: o_tx_data=sample[7:0].
  - A byte transfers on a cycle where o_tx_valid=1 and i_tx_ready=1. On transfer, the FSM records the next byte index and goes to WAIT_BUSY; o_tx_valid drops the next cycle.
  - WAIT_BUSY: wait for i_tx_ready=0, which guards against double-send while uart_tx latches the byte; then go to WAIT_READY.
  - WAIT_READY: wait for i_tx_ready=1, then go to the next byte state. After B2, go to IDLE.
  - A frame in progress always completes, even if i_enb falls mid-frame.
- o_tx_data changes only on state entry; it is stable while o_tx_valid=1.
- o_busy = (state≠IDLE) OR (o_fifo_level≠0).
- Reset mid-frame aborts the frame immediately and drops o_tx_valid; the partial frame is not resumed.

Test Plan:
- Reset, SAMPLE_DIV=8, i_enb=1, i_adc_data=12'h3C7, uart model (ready drops 2 cycles after transfer, returns after 20) -> bytes A5, 03, C7 in order; next frame A5, 13, C7.
- Hold i_tx_ready=1 permanently (non-compliant model) -> exactly one byte sent; FSM stalls in WAIT_BUSY, no duplicate transfers.
- Slow uart (ready low 200 cycles), SAMPLE_DIV=8, FIFO_DEPTH=4 -> o_fifo_level saturates at 4, o_overflow=1 and sticky, emitted seq values show gaps, no corruption of queued entries.
- Deassert i_enb during byte B1 -> B1 and B2 still sent, then no further ticks or frames; o_busy falls once the FIFO is drained.
- Assert i_rst_n=0 while in WAIT_READY -> o_tx_valid, o_overflow, o_fifo_level all 0 immediately; after release, the first frame starts with seq 0.
- i_adc_data changes every cycle -> captured sample equals the value on the tick cycle (check 12'hFFF and 12'h000 boundaries).
